// File: rtl/stopwatch_display_if.sv
// Signal bundle between the stopwatch/display block and its environment.
// The master drives the timer flag and the controls, and the slave drives the display outputs.
interface stopwatch_display_if;
  logic        timer_1s_flag;
  logic        en;
  logic        clr;
  logic [15:0] display_num;
  logic [3:0]  sel;
  logic [7:0]  seg;

  modport master (
    output timer_1s_flag, en, clr,
    input  display_num, sel, seg
  );

  modport slave (
    input  timer_1s_flag, en, clr,
    output display_num, sel, seg
  );
endinterface

// File: rtl/stopwatch_display.sv
// MM:SS BCD stopwatch fed by a 1 Hz flag, multiplexed onto a 4-digit active-low 7-segment display.
// Optional macro DP_BLINK_EN makes the dp after the minute-units digit blink with the flag.
module stopwatch_display #(
  parameter int SCAN_DIV = 25000,
  parameter int CNT_W    = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  stopwatch_display_if.slave  bus
);

  logic             r_flag_d;
  logic [3:0]       r_sec_u, r_sec_t, r_min_u, r_min_t;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_sel;
  logic [7:0]       r_seg;

  logic             w_tick;
  logic [3:0]       w_sec_u, w_sec_t, w_min_u, w_min_t;
  logic [15:0]      w_num;
  logic [3:0]       w_sel;
  logic [3:0]       w_digit;
  logic [6:0]       w_seg7;
  logic             w_dp;
  logic             w_wrap;

  assign w_tick = bus.timer_1s_flag & ~r_flag_d;
  assign w_num  = {r_min_t, r_min_u, r_sec_t, r_sec_u};
  assign w_wrap = (r_cnt == CNT_W'(SCAN_DIV - 1));

  // BCD cascade; a rollover at 59:59 clears all four digits in one step
  always_comb begin
    w_sec_u = r_sec_u;
    w_sec_t = r_sec_t;
    w_min_u = r_min_u;
    w_min_t = r_min_t;
    if (bus.clr) begin
      w_sec_u = 4'd0;
      w_sec_t = 4'd0;
      w_min_u = 4'd0;
      w_min_t = 4'd0;
    end else if (w_tick && bus.en) begin
      if (r_sec_u == 4'd9) begin
        w_sec_u = 4'd0;
        if (r_sec_t == 4'd5) begin
          w_sec_t = 4'd0;
          if (r_min_u == 4'd9) begin
            w_min_u = 4'd0;
            w_min_t = (r_min_t == 4'd5) ? 4'd0 : r_min_t + 4'd1;
          end else begin
            w_min_u = r_min_u + 4'd1;
          end
        end else begin
          w_sec_t = r_sec_t + 4'd1;
        end
      end else begin
        w_sec_u = r_sec_u + 4'd1;
      end
    end
  end

  always_comb begin
    w_sel   = 4'b1110;
    w_digit = r_sec_u;
    case (r_idx)
      2'd0: begin w_sel = 4'b1110; w_digit = r_sec_u; end
      2'd1: begin w_sel = 4'b1101; w_digit = r_sec_t; end
      2'd2: begin w_sel = 4'b1011; w_digit = r_min_u; end
      2'd3: begin w_sel = 4'b0111; w_digit = r_min_t; end
      default: ;
    endcase
  end

  always_comb begin
    w_seg7 = 7'h7F;
    case (w_digit)
      4'd0: w_seg7 = 7'h40;
      4'd1: w_seg7 = 7'h79;
      4'd2: w_seg7 = 7'h24;
      4'd3: w_seg7 = 7'h30;
      4'd4: w_seg7 = 7'h19;
      4'd5: w_seg7 = 7'h12;
      4'd6: w_seg7 = 7'h02;
      4'd7: w_seg7 = 7'h78;
      4'd8: w_seg7 = 7'h00;
      4'd9: w_seg7 = 7'h10;
      default: w_seg7 = 7'h7F;
    endcase
  end

`ifdef DP_BLINK_EN
  assign w_dp = (r_idx == 2'd2) ? ~bus.timer_1s_flag : 1'b1;
`else
  assign w_dp = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_d <= 1'b0;
      r_sec_u  <= 4'd0;
      r_sec_t  <= 4'd0;
      r_min_u  <= 4'd0;
      r_min_t  <= 4'd0;
    end else begin
      r_flag_d <= bus.timer_1s_flag;
      r_sec_u  <= w_sec_u;
      r_sec_t  <= w_sec_t;
      r_min_u  <= w_min_u;
      r_min_t  <= w_min_t;
    end
  end

  // sel and seg share one register stage so digit and segment data switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
      r_sel <= 4'b1111;
      r_seg <= 8'hFF;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (w_wrap) r_idx <= r_idx + 2'd1;
      r_sel <= w_sel;
      r_seg <= {w_dp, w_seg7};
    end
  end

  assign bus.display_num = w_num;
  assign bus.sel         = r_sel;
  assign bus.seg         = r_seg;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display: counting table, latency, reset, scan order and dp.
module tb_stopwatch_display;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  stopwatch_display_if bus ();

  stopwatch_display #(.SCAN_DIV(4), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          edges;
    logic        en;
    logic        clr;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
  } slot_t;

  vec_t  vecs [8];
  slot_t slots [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge
  task automatic pulse(input logic e, input logic c);
    bus.en = e;
    bus.clr = c;
    bus.timer_1s_flag = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    @(posedge clk); #1;
    bus.timer_1s_flag = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic wait_sel(input logic [3:0] s, input string name);
    int n;
    n = 0;
    while (bus.sel !== s && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("FAIL %s: sel %b never seen, got %b", name, s, bus.sel);
    end
  endtask

  logic [7:0] dp_exp;

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.timer_1s_flag = 1'b0;
    bus.en = 1'b0;
    bus.clr = 1'b0;

    vecs[0] = '{10,   1'b1, 1'b0, 16'h0010};
    vecs[1] = '{5,    1'b0, 1'b0, 16'h0010};
    vecs[2] = '{1,    1'b1, 1'b0, 16'h0011};
    vecs[3] = '{49,   1'b1, 1'b0, 16'h0100};
    vecs[4] = '{1,    1'b1, 1'b1, 16'h0000};
    vecs[5] = '{3599, 1'b1, 1'b0, 16'h5959};
    vecs[6] = '{1,    1'b1, 1'b0, 16'h0000};
    vecs[7] = '{754,  1'b1, 1'b0, 16'h1234};

    slots[0] = '{4'b1110, 8'h99};
    slots[1] = '{4'b1101, 8'hB0};
    slots[2] = '{4'b1011, 8'hA4};
    slots[3] = '{4'b0111, 8'hF9};

    #12;
    check("reset_num", 32'(bus.display_num), 32'h0000);
    check("reset_sel", 32'(bus.sel), 32'hF);
    check("reset_seg", 32'(bus.seg), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("scan_start_sel", 32'(bus.sel), 32'b1110);
    check("scan_start_seg", 32'(bus.seg), 32'hC0);

    // Update lands on the edge that first sees the flag high
    @(posedge clk); #1;
    bus.en = 1'b1;
    bus.timer_1s_flag = 1'b1;
    @(negedge clk);
    check("latency_before", 32'(bus.display_num), 32'h0000);
    @(negedge clk);
    check("latency_after", 32'(bus.display_num), 32'h0001);
    @(negedge clk);
    check("flag_held_no_retick", 32'(bus.display_num), 32'h0001);
    @(posedge clk); #1;
    bus.timer_1s_flag = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 122; i++) pulse(1'b1, 1'b0);
    check("pre_reset_num", 32'(bus.display_num), 32'h0203);
    rst_n = 1'b0;
    #1;
    check("async_reset_num", 32'(bus.display_num), 32'h0000);
    check("async_reset_sel", 32'(bus.sel), 32'hF);
    check("async_reset_seg", 32'(bus.seg), 32'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 8; v++) begin
      for (int k = 0; k < vecs[v].edges; k++) pulse(vecs[v].en, vecs[v].clr);
      check($sformatf("vec%0d_num", v), 32'(bus.display_num), 32'(vecs[v].exp));
    end

    bus.en = 1'b0;
    @(negedge clk);
    wait_sel(4'b0111, "scan_sync_a");
    wait_sel(4'b1110, "scan_sync_b");
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        check($sformatf("scan_sel_s%0d_c%0d", s, c), 32'(bus.sel), 32'(slots[s].sel));
        check($sformatf("scan_seg_s%0d_c%0d", s, c), 32'(bus.seg), 32'(slots[s].seg));
        @(negedge clk);
      end
    end

`ifdef DP_BLINK_EN
    dp_exp = 8'h24;
`else
    dp_exp = 8'hA4;
`endif
    bus.timer_1s_flag = 1'b1;
    wait_sel(4'b0111, "dp_sync_a");
    wait_sel(4'b1011, "dp_sync_b");
    check("dp_flag_high", 32'(bus.seg), 32'(dp_exp));
    bus.timer_1s_flag = 1'b0;
    wait_sel(4'b0111, "dp_sync_c");
    wait_sel(4'b1011, "dp_sync_d");
    check("dp_flag_low", 32'(bus.seg), 32'hA4);
    check("dp_hold_num", 32'(bus.display_num), 32'h1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
